// File: rtl/spi_tx_ctrl.sv
// SPI transmit frame sequencer: FIFO fetch, P2S load/shift strobes, SCLK (mode 0), CS_N framing.
// Define SPI_TX_LDAC_EN to drive LDAC_N low for the whole GAP interval; otherwise LDAC_N is held at 1.
module spi_tx_ctrl #(
  parameter int HALF   = 2,
  parameter int CS_GAP = 4
) (
  input  logic clk,
  input  logic iRST_N,
  input  logic en,
  input  logic fifo_empty,
  output logic fifo_rd,
  output logic p2s_en,
  output logic p2s_load,
  output logic sclk,
  output logic cs_n,
  output logic ldac_n,
  output logic busy,
  output logic frame_done
);

  localparam int HW = $clog2(HALF) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_LOW, S_HIGH, S_HOLD, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [3:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          shift_d, ldac_n_d;

  logic fifo_rd_q, p2s_en_q, p2s_load_q, sclk_q, cs_n_q, ldac_n_q, busy_q, frame_done_q;

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:  if (en && !fifo_empty) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        half_d  = '0;
        bit_d   = '0;
        state_d = S_LOW;
      end
      S_LOW: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          state_d = S_HIGH;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      S_HIGH: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (bit_q != 4'd15) begin
            bit_d   = bit_q + 4'd1;
            state_d = S_LOW;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      S_HOLD: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values, so each strobe lines up with its state cycle.
  assign shift_d = (state_d == S_HIGH) && (half_d == HALF_LAST) && (bit_d != 4'd15);

`ifdef SPI_TX_LDAC_EN
  assign ldac_n_d = (state_d != S_GAP);
`else
  assign ldac_n_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      half_q       <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      fifo_rd_q    <= 1'b0;
      p2s_en_q     <= 1'b0;
      p2s_load_q   <= 1'b0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      ldac_n_q     <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      fifo_rd_q    <= (state_d == S_FETCH);
      p2s_en_q     <= (state_d == S_LOAD) || shift_d;
      p2s_load_q   <= (state_d == S_LOAD);
      sclk_q       <= (state_d == S_HIGH);
      cs_n_q       <= !(state_d inside {S_LOW, S_HIGH, S_HOLD});
      ldac_n_q     <= ldac_n_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_d == S_GAP) && (state_q != S_GAP);
    end
  end

  assign fifo_rd    = fifo_rd_q;
  assign p2s_en     = p2s_en_q;
  assign p2s_load   = p2s_load_q;
  assign sclk       = sclk_q;
  assign cs_n       = cs_n_q;
  assign ldac_n     = ldac_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
